// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with input synchronizer, receive FIFO and error pulses
module uart_receiver #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_error,
   output logic       overrun,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state, state_n;
   logic          rx_m, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    sh, sh_n;
   logic          tick, push, wr, pop, full, empty, fe_n, ov_n;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wptr, rptr;

   assign tick      = cnt == '0;
   assign empty     = wptr == rptr;
   assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign wr        = push && (!full || pop);
   assign out_data  = mem[rptr[AW-1:0]];
   assign busy      = state != IDLE;

   // two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // frame FSM next-state: baud counter counts down to zero, every zero is a sample point
   always_comb begin
      state_n = state;
      cnt_n   = tick ? cnt : cnt - CW'(1);
      idx_n   = idx;
      sh_n    = sh;
      push    = 1'b0;
      fe_n    = 1'b0;
      ov_n    = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = HALF_M1;
            end
         end
         START: begin
            if (tick) begin
               state_n = rx_s ? IDLE : DATA;
               cnt_n   = BIT_M1;
               idx_n   = 3'd0;
            end
         end
         DATA: begin
            if (tick) begin
               sh_n    = {rx_s, sh[7:1]};
               idx_n   = idx + 3'd1;
               cnt_n   = BIT_M1;
               state_n = idx == 3'd7 ? STOP : DATA;
            end
         end
         STOP: begin
            if (tick) begin
               push    = rx_s;
               ov_n    = rx_s && full && !pop;
               fe_n    = !rx_s;
               state_n = rx_s ? IDLE : BRK;
            end
         end
         BRK: begin
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // frame FSM registers and single-cycle error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= 3'd0;
         sh          <= 8'd0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         sh          <= sh_n;
         frame_error <= fe_n;
         overrun     <= ov_n;
      end
   end

   // FIFO pointers; a pop on the same edge frees the slot a full push needs
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + (AW+1)'(1);
         if (pop) rptr <= rptr + (AW+1)'(1);
      end
   end

   // FIFO storage, written at the stop-bit sample with the assembled byte
   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= sh;
   end
endmodule
